// File: rtl/depth_test_writer.sv
// depth_test_writer: z-buffer read-modify-write stage between a fragment source and a dual-port BRAM.
// Define DEPTH_TEST_WRITER_STATS_EN to add saturating pass/fail fragment counters.
module depth_test_writer #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_W     = 16,
  parameter int COLOR_W     = 16,
  parameter int RAM_LATENCY = 2,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = {COLOR_W{1'b0}}
) (
  input  logic                       clk_in,
  input  logic                       rst_in_n,
  input  logic                       frag_valid_in,
  output logic                       frag_ready_out,
  input  logic [ADDR_W-1:0]          frag_addr_in,
  input  logic [DEPTH_W-1:0]         frag_depth_in,
  input  logic [COLOR_W-1:0]         frag_color_in,
  input  logic                       clear_in,
  output logic                       busy_out,
  output logic [ADDR_W-1:0]          addra_out,
  output logic                       ena_out,
  output logic                       regcea_out,
  input  logic [DEPTH_W+COLOR_W-1:0] douta_in,
  output logic [ADDR_W-1:0]          addrb_out,
  output logic [DEPTH_W+COLOR_W-1:0] dinb_out,
  output logic                       enb_out,
  output logic                       web_out
`ifdef DEPTH_TEST_WRITER_STATS_EN
  ,
  output logic [31:0]                pass_count_out,
  output logic [31:0]                fail_count_out
`endif
);

  localparam int W  = DEPTH_W + COLOR_W;
  localparam int NS = RAM_LATENCY + 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;

  logic               stg_vld_r   [NS];
  logic [ADDR_W-1:0]  stg_addr_r  [NS];
  logic [DEPTH_W-1:0] stg_depth_r [NS];
  logic [COLOR_W-1:0] stg_color_r [NS];
  logic               wr_vld_r;
  logic [ADDR_W-1:0]  wr_addr_r;

  logic [ADDR_W-1:0]  clr_addr_r;
  logic               ena_r;
  logic [ADDR_W-1:0]  addra_r;
  logic               web_r;
  logic [ADDR_W-1:0]  addrb_r;
  logic [W-1:0]       dinb_r;
  logic               busy_r;

  logic               hazard_s;
  logic               sb_empty_s;
  logic               ready_s;
  logic               accept_s;
  logic [DEPTH_W-1:0] stored_depth_s;
  logic               closer_s;
  logic               pass_s;
  logic               fail_s;
  logic               clear_entry_s;
  logic               web_s;
  logic [ADDR_W-1:0]  addrb_s;
  logic [W-1:0]       dinb_s;
  logic               unused_color_s;

  assign stored_depth_s = douta_in[W-1 -: DEPTH_W];
  assign unused_color_s = ^douta_in[COLOR_W-1:0];
  assign closer_s       = stg_depth_r[RAM_LATENCY] < stored_depth_s;
  assign pass_s         = stg_vld_r[RAM_LATENCY] & closer_s;
  assign fail_s         = stg_vld_r[RAM_LATENCY] & ~closer_s;
  assign accept_s       = frag_valid_in & ready_s;
  assign clear_entry_s  = (state_r == ST_DRAIN) && (state_s == ST_CLEAR);

  // Scoreboard lookup: any in-flight slot holding the incoming address blocks it
  always_comb begin
    hazard_s   = 1'b0;
    sb_empty_s = ~wr_vld_r;
    if (wr_vld_r && (wr_addr_r == frag_addr_in)) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = hazard_s;
    end
    for (int i = 0; i < NS; i++) begin
      if (stg_vld_r[i]) begin
        sb_empty_s = 1'b0;
        if (stg_addr_r[i] == frag_addr_in) begin
          hazard_s = 1'b1;
        end else begin
          hazard_s = hazard_s;
        end
      end else begin
        sb_empty_s = sb_empty_s;
      end
    end
    ready_s = (state_r == ST_RUN) && !hazard_s;
  end

  // Next-state logic for the run / drain / clear sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (clear_in) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (sb_empty_s) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_r == ADDR_LAST) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      default: state_s = ST_RUN;
    endcase
  end

  // Port B source select: sweep word while clearing, otherwise a passing fragment
  always_comb begin
    web_s   = 1'b0;
    addrb_s = addrb_r;
    dinb_s  = dinb_r;
    if (state_r == ST_CLEAR) begin
      web_s   = 1'b1;
      addrb_s = clr_addr_r;
      dinb_s  = {{DEPTH_W{1'b1}}, CLEAR_COLOR};
    end else if (pass_s) begin
      web_s   = 1'b1;
      addrb_s = stg_addr_r[RAM_LATENCY];
      dinb_s  = {stg_depth_r[RAM_LATENCY], stg_color_r[RAM_LATENCY]};
    end else begin
      web_s   = 1'b0;
    end
  end

  // State register and busy flag
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_r <= ST_RUN;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_RUN);
    end
  end

  // Fragment pipeline: stage i is visible i+1 cycles after acceptance
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      for (int i = 0; i < NS; i++) begin
        stg_vld_r[i]   <= 1'b0;
        stg_addr_r[i]  <= {ADDR_W{1'b0}};
        stg_depth_r[i] <= {DEPTH_W{1'b0}};
        stg_color_r[i] <= {COLOR_W{1'b0}};
      end
      wr_vld_r  <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
    end else begin
      stg_vld_r[0]   <= accept_s;
      stg_addr_r[0]  <= frag_addr_in;
      stg_depth_r[0] <= frag_depth_in;
      stg_color_r[0] <= frag_color_in;
      for (int i = 1; i < NS; i++) begin
        stg_vld_r[i]   <= stg_vld_r[i-1];
        stg_addr_r[i]  <= stg_addr_r[i-1];
        stg_depth_r[i] <= stg_depth_r[i-1];
        stg_color_r[i] <= stg_color_r[i-1];
      end
      wr_vld_r  <= stg_vld_r[RAM_LATENCY];
      wr_addr_r <= stg_addr_r[RAM_LATENCY];
    end
  end

  // Port A read request, issued the cycle after acceptance
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      ena_r   <= 1'b0;
      addra_r <= {ADDR_W{1'b0}};
    end else begin
      ena_r   <= accept_s;
      addra_r <= accept_s ? frag_addr_in : addra_r;
    end
  end

  // Port B write register
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      web_r   <= 1'b0;
      addrb_r <= {ADDR_W{1'b0}};
      dinb_r  <= {W{1'b0}};
    end else begin
      web_r   <= web_s;
      addrb_r <= addrb_s;
      dinb_r  <= dinb_s;
    end
  end

  // Sweep address counter; wraps back to zero as the sweep finishes
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      clr_addr_r <= {ADDR_W{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      clr_addr_r <= clr_addr_r + ADDR_ONE;
    end else begin
      clr_addr_r <= {ADDR_W{1'b0}};
    end
  end

`ifdef DEPTH_TEST_WRITER_STATS_EN
  logic [31:0] pass_cnt_r;
  logic [31:0] fail_cnt_r;

  // Saturating compare-outcome counters, zeroed on entry to a clear sweep
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      pass_cnt_r <= 32'd0;
      fail_cnt_r <= 32'd0;
    end else if (clear_entry_s) begin
      pass_cnt_r <= 32'd0;
      fail_cnt_r <= 32'd0;
    end else begin
      if (pass_s && (pass_cnt_r != 32'hFFFF_FFFF)) begin
        pass_cnt_r <= pass_cnt_r + 32'd1;
      end else begin
        pass_cnt_r <= pass_cnt_r;
      end
      if (fail_s && (fail_cnt_r != 32'hFFFF_FFFF)) begin
        fail_cnt_r <= fail_cnt_r + 32'd1;
      end else begin
        fail_cnt_r <= fail_cnt_r;
      end
    end
  end

  assign pass_count_out = pass_cnt_r;
  assign fail_count_out = fail_cnt_r;
`else
  logic unused_stats_s;
  assign unused_stats_s = fail_s ^ clear_entry_s;
`endif

  assign frag_ready_out = ready_s;
  assign busy_out       = busy_r;
  assign ena_out        = ena_r;
  assign addra_out      = addra_r;
  assign regcea_out     = 1'b1;
  assign web_out        = web_r;
  assign enb_out        = web_r;
  assign addrb_out      = addrb_r;
  assign dinb_out       = dinb_r;

endmodule
